// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, registered
// rx_done / frame_err pulses and a BREAK state that swallows held-low lines.
module uart_byte_rx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state, state_next;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             cnt_full, cnt_half;
  logic             done_next, err_next, shift_en;

  assign cnt_full = (cnt == CNT_FULL);
  assign cnt_half = (cnt == CNT_HALF);
  assign busy     = (state != IDLE);

  // Idle-high reset value keeps a reset release from looking like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: if (cnt_half) state_next = rx_s ? IDLE : DATA;
      DATA:  if (cnt_full && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (cnt_full) state_next = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done_next = 1'b0;
    err_next  = 1'b0;
    shift_en  = 1'b0;
    case (state)
      DATA:    shift_en  = cnt_full;
      STOP: begin
        done_next = cnt_full && rx_s;
        err_next  = cnt_full && !rx_s;
      end
      default: ;
    endcase
  end

  // Counter restarts on every state change and at each data-bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_next != state || state == IDLE || state == BREAK ||
                 (state == DATA && cnt_full)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else if (state == START) begin
      bit_idx <= 3'd0;
    end else if (shift_en) begin
      bit_idx   <= bit_idx + 3'd1;
      shift_reg <= {rx_s, shift_reg[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= done_next;
      frame_err <= err_next;
      if (done_next) rx_data <= shift_reg;
    end
  end

endmodule
